// File: rtl/demux_l2_pkg.sv
// Shared types for the 2:1 lane de-interleaver.
// Phase encoding, default width and idle fill.
package demux_pkg;

  typedef enum logic {
    PH_LANE0 = 1'b0,
    PH_LANE1 = 1'b1
  } phase_e;

  localparam int DEF_WIDTH = 8;

  localparam logic [DEF_WIDTH-1:0] DATA_IDLE = '0;

endpackage

// File: rtl/demux_l2.sv
// Splits a fast byte lane into two half-rate lanes.
// Optional pair counter enabled by DEMUXL2_CNT_EN.
module demux_l2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out0,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out1,
  output logic [WIDTH-1:0] data_out1,
  output logic             out_stb
`ifdef DEMUXL2_CNT_EN
  ,
  output logic [CNT_W-1:0] pair_cnt
`endif
);

  localparam logic [WIDTH-1:0] IDLE =
    WIDTH'(DATA_IDLE);

  phase_e           phase;
  logic [WIDTH-1:0] hold_data;
  logic             hold_vld;
  logic [WIDTH-1:0] slot_data;

  // Invalid slots carry zero data downstream.
  always_comb begin
    slot_data = valid_in ? data_in : IDLE;
  end

  // Phase FSM: capture lane 0, then emit the pair with lane 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= PH_LANE0;
      hold_data  <= IDLE;
      hold_vld   <= 1'b0;
      valid_out0 <= 1'b0;
      data_out0  <= IDLE;
      valid_out1 <= 1'b0;
      data_out1  <= IDLE;
      out_stb    <= 1'b0;
    end else begin
      unique case (phase)
        PH_LANE0: begin
          hold_data <= slot_data;
          hold_vld  <= valid_in;
          out_stb   <= 1'b0;
          phase     <= PH_LANE1;
        end
        PH_LANE1: begin
          data_out0  <= hold_data;
          valid_out0 <= hold_vld;
          data_out1  <= slot_data;
          valid_out1 <= valid_in;
          out_stb    <= 1'b1;
          phase      <= PH_LANE0;
        end
        default: begin
          phase <= PH_LANE0;
        end
      endcase
    end
  end

`ifdef DEMUXL2_CNT_EN
  // Saturating count of pairs where both lanes were valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_cnt <= '0;
    end else if (phase == PH_LANE1 &&
                 hold_vld && valid_in &&
                 pair_cnt != '1) begin
      pair_cnt <= pair_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_demux_l2.sv
// Randomised and directed bench for demux_l2.
// Reference model rebuilds output pairs from the slot history.
module tb_demux_l2;

`ifdef DEMUXL2_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_out0, valid_out1, out_stb;
  logic [7:0] data_out0, data_out1;
`ifdef DEMUXL2_CNT_EN
  logic [CW-1:0] pair_cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux_l2 #(.WIDTH(8), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out0(valid_out0),
    .data_out0 (data_out0),
    .valid_out1(valid_out1),
    .data_out1 (data_out1),
    .out_stb   (out_stb)
`ifdef DEMUXL2_CNT_EN
    ,
    .pair_cnt  (pair_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Slot history since the last reset: {valid, data}.
  logic [8:0] slots[$];
  int         n_edges = 0;

  int         m_v0, m_v1, m_stb, m_cnt;
  logic [7:0] m_d0, m_d1;

  function automatic void model_eval();
    int p;
    int full;
    m_v0 = 0; m_v1 = 0; m_stb = 0; m_cnt = 0;
    m_d0 = 8'h00; m_d1 = 8'h00;
    p = n_edges / 2;
    if (p > 0) begin
      m_v0 = int'(slots[2*p-2][8]);
      m_d0 = m_v0 != 0 ? slots[2*p-2][7:0] : 8'h00;
      m_v1 = int'(slots[2*p-1][8]);
      m_d1 = m_v1 != 0 ? slots[2*p-1][7:0] : 8'h00;
      m_stb = (n_edges % 2 == 0) ? 1 : 0;
    end
    full = 0;
    for (int k = 0; k < p; k++)
      if (slots[2*k][8] && slots[2*k+1][8])
        full++;
    m_cnt = full > (2**CW - 1) ? (2**CW - 1) : full;
  endfunction

  // Per-edge compare against the model.
  always @(posedge clk) begin
    logic       r, v;
    logic [7:0] d;
    r = reset; v = valid_in; d = data_in;
    if (r) begin
      slots.delete();
      n_edges = 0;
    end else begin
      slots.push_back({v, d});
      n_edges++;
    end
    model_eval();
    #1;
    chk("valid_out0", 32'(valid_out0), 32'(m_v0));
    chk("data_out0", 32'(data_out0), 32'(m_d0));
    chk("valid_out1", 32'(valid_out1), 32'(m_v1));
    chk("data_out1", 32'(data_out1), 32'(m_d1));
    chk("out_stb", 32'(out_stb), 32'(m_stb));
`ifdef DEMUXL2_CNT_EN
    chk("pair_cnt", 32'(pair_cnt), 32'(m_cnt));
`endif
  end

  task automatic slot(input logic v,
                      input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm,
                     input logic s, input logic a,
                     input logic [7:0] x,
                     input logic b,
                     input logic [7:0] y);
    chk({nm, "_stb"}, 32'(out_stb), 32'(s));
    chk({nm, "_v0"}, 32'(valid_out0), 32'(a));
    chk({nm, "_d0"}, 32'(data_out0), 32'(x));
    chk({nm, "_v1"}, 32'(valid_out1), 32'(b));
    chk({nm, "_d1"}, 32'(data_out1), 32'(y));
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) slot(1'b1, 8'hEE);
    lit("reset", 0, 0, 8'h00, 0, 8'h00);
    reset = 1'b0;

    slot(1'b1, 8'hA1);
    lit("first_half", 0, 0, 8'h00, 0, 8'h00);
    slot(1'b1, 8'hB2);
    lit("first_pair", 1, 1, 8'hA1, 1, 8'hB2);

    for (int i = 0; i < 16; i++)
      slot(1'b1, 8'(8'h10 + i));
    lit("stream_end", 1, 1, 8'h1E, 1, 8'h1F);

    slot(1'b0, 8'h55);
    lit("stream_hold", 0, 1, 8'h1E, 1, 8'h1F);
    slot(1'b1, 8'h66);
    lit("inv_lane0", 1, 0, 8'h00, 1, 8'h66);

    slot(1'b0, 8'hAA);
    slot(1'b0, 8'hBB);
    lit("both_inv", 1, 0, 8'h00, 0, 8'h00);

    slot(1'b1, 8'h77);
    reset = 1'b1;
    slot(1'b1, 8'h88);
    lit("mid_reset", 0, 0, 8'h00, 0, 8'h00);
    reset = 1'b0;
    slot(1'b1, 8'h01);
    slot(1'b1, 8'h02);
    lit("post_reset", 1, 1, 8'h01, 1, 8'h02);

`ifdef DEMUXL2_CNT_EN
    reset = 1'b1;
    slot(1'b0, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      slot(1'b1, 8'(i));
      slot(1'b1, 8'(i + 100));
    end
    chk("cnt_sat", 32'(pair_cnt), 32'd3);
    slot(1'b1, 8'h3C);
    slot(1'b0, 8'h3D);
    chk("cnt_half", 32'(pair_cnt), 32'd3);
    reset = 1'b1;
    slot(1'b0, 8'h00);
    chk("cnt_reset", 32'(pair_cnt), 32'd0);
    reset = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      slot(1'($urandom_range(0, 3) != 0),
           8'($urandom));
    end
    reset = 1'b0;
    slot(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
